sram_req_adapter: RTL and testbench

SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

---
 rtl/sram_adapter_pkg.sv | 21 ++
 rtl/sram_rsp_fifo.sv | 61 ++++++
 rtl/sram_req_adapter.sv | 92 +++++++++
 tb/tb_sram_req_adapter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_adapter_pkg.sv
// Shared constants for the SRAM request adapter and its response buffer.
// Ports: none (package only).
// Response entries are packed as {we, data}: data in the low bits, write flag as MSB.
package sram_adapter_pkg;

  localparam int unsigned RSP_DEPTH_DEFAULT = 2;

  // Bit position of the data field inside a response entry.
  localparam int unsigned RSP_DATA_LSB = 0;

  // Entry width for a given SRAM word width: data plus one write-flag bit.
  function automatic int unsigned rsp_entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

  // Bit position of the write flag inside a response entry.
  function automatic int unsigned rsp_we_bit(input int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response buffer: DEPTH-entry FIFO, head visible combinationally (zero when empty).
// Ports: push_i/push_data_i write side, pop_i/pop_data_o read side, count_o/full_o/empty_o status.
// A push while full is ignored unless a pop happens in the same cycle.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count == '0);
  assign full_o     = (count == CNT_W'(DEPTH));
  assign count_o    = count;
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = empty_o ? '0 : mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= push_data_i;
  end

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a 1-cycle-latency SRAM, responses returned in order via a FIFO.
// Ports: req_* upstream request, rsp_* downstream response, sram_* SRAM macro side.
// Requests are only accepted when the response FIFO is guaranteed a slot (count + inflight - pop).
module sram_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = RSP_DEPTH_DEFAULT,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int unsigned BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BE_WIDTH-1:0]   sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned ENTRY_W = rsp_entry_width(DATA_WIDTH);
  localparam int unsigned WE_BIT  = rsp_we_bit(DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;

  logic               inflight;
  logic               inflight_we;
  logic               pop;
  logic               empty;
  logic               unused_full;
  logic [CNT_W-1:0]   count;
  logic [OCC_W-1:0]   occ;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

  // Occupancy after this cycle's pop; the in-flight read must already own a slot.
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign occ         = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign req_ready_o = occ < OCC_W'(RSP_DEPTH);

  assign sram_req_o   = req_valid_i && req_ready_o;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
    end else begin
      inflight    <= sram_req_o;
      inflight_we <= sram_req_o && req_we_i;
    end
  end

  // Write responses carry zero data so the SRAM's read port is ignored for them.
  assign push_data = {inflight_we, inflight_we ? {DATA_WIDTH{1'b0}} : sram_rdata_i};

  sram_rsp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .count_o     (count),
    .full_o      (unused_full),
    .empty_o     (empty)
  );

  // The head reads as zero when empty, so no extra gating is needed here.
  assign rsp_valid_o = !empty;
  assign rsp_we_o    = head[WE_BIT];
  assign rsp_rdata_o = head[RSP_DATA_LSB +: DATA_WIDTH];

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: SRAM model, reference memory, scoreboard and monitor.
module tb_sram_req_adapter;
  localparam int DW = 64, NW = 1024, AW = 10, BW = 8, DEPTH = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata = '0;
  logic [BW-1:0] sram_be;

  int tests = 0, fails = 0, cyc = 0, acc_cnt = 0;

  typedef struct { logic [DW:0] exp; int cyc; } sb_t;
  sb_t         sbq[$];
  logic [DW:0] rsp_hist[$];
  int          lat_hist[$], pop_cyc_hist[$];

  logic [DW-1:0] sram_mem [NW] = '{default: '0};
  logic [DW-1:0] ref_mem  [NW] = '{default: '0};

  sram_req_adapter #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-port SRAM with byte-masked writes and 1-cycle read latency.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m = '0;
    for (int b = 0; b < BW; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: transaction-level model of the adapter. A request accepted in cycle N
  // occupies a slot until popped and becomes visible at the output from cycle N+2.
  initial begin
    int  outstanding = 0;
    bit  acc_prev = 0;
    bit  acc, pop;
    sb_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_outputs", {93'd0, rsp_valid, rsp_we, |rsp_rdata}, 96'd0);
        if (!req_valid) chk("rst_sram_req", {95'd0, sram_req}, 96'd0);
        sbq.delete();
        outstanding = 0;
        acc_prev = 0;
      end else begin
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        chk("rsp_valid", {95'd0, rsp_valid}, {95'd0, (outstanding - int'(acc_prev)) > 0});
        chk("req_ready", {95'd0, req_ready}, {95'd0, (outstanding - int'(pop)) < DEPTH});
        chk("sram_req", {95'd0, sram_req}, {95'd0, acc});
        if (req_valid)
          chk("sram_pass", {13'd0, sram_we, sram_addr, sram_wdata, sram_be},
                           {13'd0, req_we, req_addr, req_wdata, req_be});
        if (!rsp_valid) chk("empty_out", {31'd0, rsp_we, rsp_rdata}, 96'd0);
        if (pop) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_we, rsp_rdata}, 96'hX);
          end else begin
            e = sbq.pop_front();
            chk("rsp_data", {31'd0, rsp_we, rsp_rdata}, {31'd0, e.exp});
            lat_hist.push_back(cyc - e.cyc);
          end
          rsp_hist.push_back({rsp_we, rsp_rdata});
          pop_cyc_hist.push_back(cyc);
        end
        if (acc) begin
          acc_cnt++;
          if (req_we) begin
            sbq.push_back('{exp: {1'b1, {DW{1'b0}}}, cyc: cyc});
            ref_mem[req_addr] = (ref_mem[req_addr] & ~be_mask(req_be)) | (req_wdata & be_mask(req_be));
          end else begin
            sbq.push_back('{exp: {1'b0, ref_mem[req_addr]}, cyc: cyc});
          end
        end
        outstanding = outstanding + int'(acc) - int'(pop);
        acc_prev = acc;
      end
    end
  end

  // Entered and left at posedge+1; holds the request until the handshake.
  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    bit took = 0;
    int t = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!took && t < 100) begin
      @(negedge clk); took = req_ready; t++;
      @(posedge clk); #1;
    end
    if (!took) chk("req_timeout", 96'd0, 96'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pops(input int n);
    int t = 0;
    while (rsp_hist.size() < n && t < 200) begin @(posedge clk); #1; t++; end
    chk("pop_wait", {95'd0, rsp_hist.size() >= n}, 96'd1);
  endtask

  initial begin
    int  base, t0, t1, idx, t;
    bit  took;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", {95'd0, req_ready}, 96'd1);
    rsp_ready = 1;
    @(posedge clk); #1;

    // Read after write at 0x010
    base = rsp_hist.size();
    run_req(1, 10'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    run_req(0, 10'h010, '0, '0);
    idle(1);
    wait_pops(base + 2);
    chk("raw_wr_rsp", {31'd0, rsp_hist[base]}, {31'd0, 1'b1, 64'h0});
    chk("raw_rd_rsp", {31'd0, rsp_hist[base+1]}, {31'd0, 1'b0, 64'hDEADBEEF_CAFEF00D});
    chk("raw_latency", lat_hist[base+1], 96'd2);

    // Byte enables
    base = rsp_hist.size();
    run_req(1, 10'h020, {DW{1'b1}}, 8'hFF);
    run_req(1, 10'h020, '0, 8'h0F);
    run_req(0, 10'h020, '0, '0);
    idle(1);
    wait_pops(base + 3);
    chk("be_merge", {31'd0, rsp_hist[base+2]}, {31'd0, 1'b0, 64'hFFFFFFFF_00000000});

    // Back-to-back reads
    base = rsp_hist.size();
    t0 = cyc;
    for (int i = 0; i < 16; i++) run_req(0, AW'(i), '0, '0);
    t1 = cyc;
    idle(1);
    chk("b2b_cycles", t1 - t0, 96'd16);
    wait_pops(base + 16);
    chk("b2b_span", pop_cyc_hist[base+15] - pop_cyc_hist[base], 96'd15);

    // Backpressure: preload distinct words, then offer 4 reads with rsp_ready low
    for (int i = 0; i < 4; i++) run_req(1, AW'(10'h100 + i), {32'hB0B0_0000, 32'(i)}, 8'hFF);
    idle(2);
    base = rsp_hist.size();
    rsp_ready = 0;
    idx = 0;
    req_valid = 1; req_we = 0; req_addr = 10'h100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); took = req_ready;
      @(posedge clk); #1;
      if (took) begin idx++; req_addr = AW'(10'h100 + idx); end
    end
    chk("bp_accepted", idx, 96'd2);
    chk("bp_ready_low", {95'd0, req_ready}, 96'd0);
    rsp_ready = 1;
    t = 0;
    while (idx < 4 && t < 50) begin
      @(negedge clk); took = req_ready;
      @(posedge clk); #1;
      t++;
      if (took) begin idx++; req_addr = AW'(10'h100 + idx); end
    end
    idle(1);
    wait_pops(base + 4);
    for (int i = 0; i < 4; i++)
      chk("bp_order", {31'd0, rsp_hist[base+i]}, {31'd0, 1'b0, 32'hB0B0_0000, 32'(i)});

    // Reset with one buffered and one in-flight response
    rsp_ready = 0;
    run_req(0, 10'h100, '0, '0);
    run_req(0, 10'h101, '0, '0);
    req_valid = 0;
    base = rsp_hist.size();
    #1 rst_n = 0;
    #1 chk("rst_rsp_valid", {95'd0, rsp_valid}, 96'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rsp_ready = 1;
    chk("rst_release_ready", {95'd0, req_ready}, 96'd1);
    idle(10);
    chk("rst_no_stale", rsp_hist.size() - base, 96'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); took = req_valid && req_ready;
      @(posedge clk); #1;
      if (!req_valid || took) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = $urandom_range(0, 1) == 1;
        req_addr  = AW'($urandom_range(0, 15));
        req_wdata = {$urandom, $urandom};
        req_be    = BW'($urandom_range(0, 255));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 0;
    rsp_ready = 1;
    idle(10);
    chk("drain_empty", sbq.size(), 96'd0);
    chk("random_activity", {95'd0, acc_cnt > 1000}, 96'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
